// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch sequencer: PC update opcodes, redirect kinds
// and sequencer states, plus the redirect-kind to PC-op mapping.
package pc_sequencer_pkg;

   typedef enum logic [2:0] {
      PcStop   = 3'd0,
      PcIncr   = 3'd1,
      PcJAL    = 3'd2,
      PcJALR   = 3'd3,
      PcBranch = 3'd4,
      PcRsvd   = 3'd5
   } pc_op_e;

   typedef enum logic [1:0] {
      RdJal    = 2'b00,
      RdJalr   = 2'b01,
      RdBranch = 2'b10,
      RdNone   = 2'b11
   } redir_kind_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      APPLY = 3'd3,
      HALT  = 3'd4
   } seq_state_e;

   // Kind 11 never reaches the latch, so it maps to a harmless stop.
   function automatic pc_op_e kind_to_op(input redir_kind_e k);
      case (k)
         RdJal:    return PcJAL;
         RdJalr:   return PcJALR;
         RdBranch: return PcBranch;
         default:  return PcStop;
      endcase
   endfunction

endpackage

// File: rtl/pc_seq_redirect_latch.sv
// Pending-redirect register: holds the PC op of the most recent redirect
// until the sequencer applies it. A new load always overwrites.
module pc_seq_redirect_latch
   import pc_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [1:0] i_kind,
   input  logic       i_clear,
   output logic       o_pend_valid,
   output pc_op_e     o_pend_op
);

   // Latest redirect wins; clear happens when APPLY consumes the op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_pend_valid <= 1'b0;
         o_pend_op    <= PcStop;
      end else if (i_load) begin
         o_pend_valid <= 1'b1;
         o_pend_op    <= kind_to_op(redir_kind_e'(i_kind));
      end else if (i_clear) begin
         o_pend_valid <= 1'b0;
         o_pend_op    <= PcStop;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: one outstanding imem request, redirect/halt handling,
// PC update opcode generation. Optional misaligned-target trap is enabled
// with the macro PCSEQ_MISALIGN_TRAP_EN.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_enable,
   input  logic [XLEN-1:0]  i_pc,
   output logic [2:0]       o_pc_op,
   output logic             o_imem_req_valid,
   input  logic             i_imem_req_ready,
   output logic [XLEN-1:0]  o_imem_addr,
   input  logic             i_imem_rsp_valid,
   output logic             o_imem_rsp_ready,
   output logic             o_inst_valid,
   input  logic             i_dec_ready,
   input  logic             i_redir_valid,
   input  logic [1:0]       i_redir_kind,
   input  logic [XLEN-1:0]  i_redir_target,
   input  logic             i_halt,
   output logic             o_flush,
   output logic             o_halted,
`ifdef PCSEQ_MISALIGN_TRAP_EN
   output logic             o_trap,
   output logic [XLEN-1:0]  o_trap_addr,
`endif
   output logic [CNT_W-1:0] o_fetch_cnt
);

   seq_state_e state_q, state_d;
   pc_op_e     pc_op, pend_op;
   logic       pend_valid, ld, clr;
   logic       discard_q, discard_d, stop_q, stop_d;
   logic       trap_set, cnt_inc, redir_ok, mis, take, disc_eff, req_hs;

   assign o_imem_addr = i_pc;
   assign o_pc_op     = pc_op;
   assign o_halted    = (state_q == HALT);
   assign redir_ok    = i_redir_valid && (i_redir_kind != 2'b11);
   assign req_hs      = o_imem_req_valid && i_imem_req_ready;
   // Halt outranks redirects, and nothing is taken once a stop is pending.
   assign take        = redir_ok && !i_halt && !stop_q;

`ifdef PCSEQ_MISALIGN_TRAP_EN
   assign mis = (i_redir_target[1:0] != 2'b00);
`else
   logic unused_tgt;
   assign unused_tgt = ^i_redir_target;
   assign mis        = 1'b0;
`endif

   pc_seq_redirect_latch u_latch (
      .clk          (clk),
      .rst          (rst),
      .i_load       (ld),
      .i_kind       (i_redir_kind),
      .i_clear      (clr),
      .o_pend_valid (pend_valid),
      .o_pend_op    (pend_op)
   );

   // State, discard/stop flags and the delivered-instruction counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         discard_q   <= 1'b0;
         stop_q      <= 1'b0;
         o_fetch_cnt <= '0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         stop_q    <= stop_d;
         if (cnt_inc) o_fetch_cnt <= o_fetch_cnt + CNT_W'(1);
      end
   end

`ifdef PCSEQ_MISALIGN_TRAP_EN
   // Capture the first misaligned redirect target; sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_trap      <= 1'b0;
         o_trap_addr <= '0;
      end else if (trap_set) begin
         o_trap      <= 1'b1;
         o_trap_addr <= i_redir_target;
      end
   end
`endif

   // Next-state and handshake outputs.
   always_comb begin
      state_d          = state_q;
      pc_op            = PcStop;
      o_imem_req_valid = 1'b0;
      o_imem_rsp_ready = 1'b0;
      o_inst_valid     = 1'b0;
      o_flush          = 1'b0;
      ld               = 1'b0;
      clr              = 1'b0;
      discard_d        = discard_q;
      stop_d           = stop_q;
      trap_set         = 1'b0;
      cnt_inc          = 1'b0;
      disc_eff         = 1'b0;
      case (state_q)
         IDLE: if (i_enable) state_d = REQ;
         REQ: begin
            o_imem_req_valid = 1'b1;
            if (i_halt) begin
               // An accepted request must still drain before halting.
               if (req_hs) begin
                  discard_d = 1'b1;
                  stop_d    = 1'b1;
                  state_d   = WAIT;
               end else begin
                  state_d = HALT;
               end
            end else begin
               if (take) begin
                  discard_d = 1'b1;
                  if (mis) begin
                     trap_set = 1'b1;
                     stop_d   = 1'b1;
                  end else begin
                     ld = 1'b1;
                  end
               end
               if (req_hs)            state_d = WAIT;
               else if (take && mis)  state_d = HALT;
            end
         end
         WAIT: begin
            if (i_halt) begin
               discard_d = 1'b1;
               stop_d    = 1'b1;
            end
            if (take) begin
               discard_d = 1'b1;
               if (mis) begin
                  trap_set = 1'b1;
                  stop_d   = 1'b1;
               end else begin
                  ld = 1'b1;
               end
            end
            // A redirect or halt in the response cycle kills that response too.
            disc_eff         = discard_q || i_halt || take;
            o_imem_rsp_ready = disc_eff || i_dec_ready;
            o_inst_valid     = i_imem_rsp_valid && !disc_eff;
            if (i_imem_rsp_valid && o_imem_rsp_ready) begin
               if (disc_eff) begin
                  o_flush   = 1'b1;
                  discard_d = 1'b0;
                  state_d   = stop_d ? HALT : APPLY;
               end else begin
                  pc_op   = PcIncr;
                  cnt_inc = 1'b1;
                  state_d = REQ;
               end
            end
         end
         APPLY: begin
            if (i_halt) begin
               state_d = HALT;
            end else if (take) begin
               // A newer redirect supersedes the pending op before it issues.
               if (mis) begin
                  trap_set = 1'b1;
                  state_d  = HALT;
               end else begin
                  ld = 1'b1;
               end
            end else begin
               pc_op   = pend_valid ? pend_op : PcStop;
               clr     = 1'b1;
               state_d = REQ;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_enable, i_imem_req_ready, i_imem_rsp_valid, i_dec_ready;
   logic        i_redir_valid, i_halt;
   logic [1:0]  i_redir_kind;
   logic [31:0] i_pc, i_redir_target;
   logic [2:0]  o_pc_op;
   logic        o_imem_req_valid, o_imem_rsp_ready, o_inst_valid, o_flush, o_halted;
   logic [31:0] o_imem_addr, o_fetch_cnt;
`ifdef PCSEQ_MISALIGN_TRAP_EN
   logic        o_trap;
   logic [31:0] o_trap_addr;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_pc(i_pc), .o_pc_op(o_pc_op),
      .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
      .o_imem_addr(o_imem_addr), .i_imem_rsp_valid(i_imem_rsp_valid),
      .o_imem_rsp_ready(o_imem_rsp_ready), .o_inst_valid(o_inst_valid),
      .i_dec_ready(i_dec_ready), .i_redir_valid(i_redir_valid),
      .i_redir_kind(i_redir_kind), .i_redir_target(i_redir_target),
      .i_halt(i_halt), .o_flush(o_flush), .o_halted(o_halted),
`ifdef PCSEQ_MISALIGN_TRAP_EN
      .o_trap(o_trap), .o_trap_addr(o_trap_addr),
`endif
      .o_fetch_cnt(o_fetch_cnt)
   );

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic quiet();
      i_imem_rsp_valid = 1'b0; i_redir_valid = 1'b0; i_redir_kind = 2'b00;
      i_halt = 1'b0; i_imem_req_ready = 1'b1; i_dec_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_enable = 1'b0; i_pc = 32'h0; i_redir_target = 32'h0; quiet();
      cyc(); cyc(); #1;
      checks++; if (o_pc_op !== 3'(PcStop)) begin errors++; $display("FAIL rst_pc_op: got %0d want %0d", o_pc_op, PcStop); end
      checks++; if ({o_imem_req_valid, o_imem_rsp_ready, o_inst_valid, o_flush, o_halted} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b want 00000", {o_imem_req_valid, o_imem_rsp_ready, o_inst_valid, o_flush, o_halted}); end
      checks++; if (o_fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", o_fetch_cnt); end
      cyc(); rst = 1'b0;
   endtask

   // IDLE -> REQ -> WAIT pairs with zero-wait memory: 4 instructions in 8 cycles.
   task automatic test_throughput();
      cyc(); i_enable = 1'b1; #1;
      checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", o_imem_req_valid); end
      for (int k = 0; k < 4; k++) begin
         cyc(); i_pc = 32'(k * 4); i_imem_rsp_valid = 1'b0; #1;
         checks++; if (o_imem_req_valid !== 1'b1 || o_pc_op !== 3'(PcStop) || o_imem_addr !== 32'(k * 4)) begin errors++; $display("FAIL tp_req%0d: got v=%b op=%0d a=%h want v=1 op=0 a=%h", k, o_imem_req_valid, o_pc_op, o_imem_addr, 32'(k * 4)); end
         cyc(); i_imem_rsp_valid = 1'b1; #1;
         checks++; if (o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b1 || o_pc_op !== 3'(PcIncr)) begin errors++; $display("FAIL tp_rsp%0d: got v=%b iv=%b op=%0d want v=0 iv=1 op=1", k, o_imem_req_valid, o_inst_valid, o_pc_op); end
      end
      cyc(); quiet(); i_pc = 32'h0; #1;
      checks++; if (o_fetch_cnt !== 32'd4) begin errors++; $display("FAIL tp_cnt: got %0d want 4", o_fetch_cnt); end
   endtask

   // Request held while imem is not ready; PC stays stopped.
   task automatic test_stall();
      i_imem_req_ready = 1'b0; #1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin cyc(); #1; end
         checks++; if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 32'h0 || o_pc_op !== 3'(PcStop)) begin errors++; $display("FAIL stall%0d: got v=%b a=%h op=%0d want v=1 a=0 op=0", k, o_imem_req_valid, o_imem_addr, o_pc_op); end
      end
      cyc(); i_imem_req_ready = 1'b1;
      cyc(); i_imem_rsp_valid = 1'b1; #1;
      checks++; if (o_pc_op !== 3'(PcIncr)) begin errors++; $display("FAIL stall_rsp: got %0d want 1", o_pc_op); end
      cyc(); quiet(); #1;
      checks++; if (o_fetch_cnt !== 32'd5) begin errors++; $display("FAIL stall_cnt: got %0d want 5", o_fetch_cnt); end
   endtask

   // JALR arriving with the response: response dropped, flush, then JALR.
   task automatic test_redirect_wait();
      cyc(); i_imem_rsp_valid = 1'b1; i_redir_valid = 1'b1; i_redir_kind = 2'b01; i_redir_target = 32'h100; #1;
      checks++; if (o_inst_valid !== 1'b0 || o_flush !== 1'b1 || o_pc_op !== 3'(PcStop)) begin errors++; $display("FAIL jalr_wait: got iv=%b fl=%b op=%0d want iv=0 fl=1 op=0", o_inst_valid, o_flush, o_pc_op); end
      cyc(); quiet(); #1;
      checks++; if (o_pc_op !== 3'(PcJALR) || o_flush !== 1'b0) begin errors++; $display("FAIL jalr_apply: got op=%0d fl=%b want op=3 fl=0", o_pc_op, o_flush); end
      cyc(); #1;
      checks++; if (o_imem_req_valid !== 1'b1 || o_fetch_cnt !== 32'd5) begin errors++; $display("FAIL jalr_req: got v=%b cnt=%0d want v=1 cnt=5", o_imem_req_valid, o_fetch_cnt); end
   endtask

   // Branch then JAL back to back in REQ collapse to one JAL.
   task automatic test_back_to_back();
      i_imem_req_ready = 1'b0; i_redir_valid = 1'b1; i_redir_kind = 2'b10;
      cyc(); i_redir_kind = 2'b00; #1;
      checks++; if (o_imem_req_valid !== 1'b1 || o_pc_op !== 3'(PcStop)) begin errors++; $display("FAIL b2b_req: got v=%b op=%0d want v=1 op=0", o_imem_req_valid, o_pc_op); end
      cyc(); i_redir_valid = 1'b0; i_imem_req_ready = 1'b1;
      cyc(); i_imem_rsp_valid = 1'b1; #1;
      checks++; if (o_flush !== 1'b1 || o_inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_flush: got fl=%b iv=%b want fl=1 iv=0", o_flush, o_inst_valid); end
      cyc(); quiet(); #1;
      checks++; if (o_pc_op !== 3'(PcJAL)) begin errors++; $display("FAIL b2b_apply: got %0d want 2", o_pc_op); end
      // Kind 11 is not a redirect: the instruction is delivered normally.
      cyc(); cyc(); i_imem_rsp_valid = 1'b1; i_redir_valid = 1'b1; i_redir_kind = 2'b11; #1;
      checks++; if (o_inst_valid !== 1'b1 || o_pc_op !== 3'(PcIncr) || o_flush !== 1'b0) begin errors++; $display("FAIL kind11: got iv=%b op=%0d fl=%b want iv=1 op=1 fl=0", o_inst_valid, o_pc_op, o_flush); end
      cyc(); quiet(); #1;
      checks++; if (o_fetch_cnt !== 32'd6) begin errors++; $display("FAIL kind11_cnt: got %0d want 6", o_fetch_cnt); end
   endtask

   task automatic test_halt();
      cyc(); i_halt = 1'b1; #1;
      checks++; if (o_halted !== 1'b0 || o_pc_op !== 3'(PcStop)) begin errors++; $display("FAIL halt_wait: got h=%b op=%0d want h=0 op=0", o_halted, o_pc_op); end
      cyc(); i_halt = 1'b0;
      cyc(); i_imem_rsp_valid = 1'b1; #1;
      checks++; if (o_flush !== 1'b1 || o_inst_valid !== 1'b0) begin errors++; $display("FAIL halt_drain: got fl=%b iv=%b want fl=1 iv=0", o_flush, o_inst_valid); end
      cyc(); quiet(); i_redir_valid = 1'b1; i_redir_kind = 2'b00; #1;
      checks++; if (o_halted !== 1'b1 || o_pc_op !== 3'(PcStop)) begin errors++; $display("FAIL halt_state: got h=%b op=%0d want h=1 op=0", o_halted, o_pc_op); end
      cyc(); #1;
      checks++; if (o_halted !== 1'b1 || o_pc_op !== 3'(PcStop) || o_imem_req_valid !== 1'b0 || o_fetch_cnt !== 32'd6) begin errors++; $display("FAIL halt_hold: got h=%b op=%0d v=%b cnt=%0d want h=1 op=0 v=0 cnt=6", o_halted, o_pc_op, o_imem_req_valid, o_fetch_cnt); end
      cyc(); quiet(); rst = 1'b1; i_enable = 1'b0; #1;
      checks++; if (o_halted !== 1'b0 || o_fetch_cnt !== 32'd0 || o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_rst: got h=%b cnt=%0d v=%b want 0 0 0", o_halted, o_fetch_cnt, o_imem_req_valid); end
      cyc(); rst = 1'b0;
      cyc(); #1;
      checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_idle: got %b want 0", o_imem_req_valid); end
   endtask

   // Misaligned JAL target: trap and halt when enabled, plain JAL otherwise.
   task automatic test_misalign();
      cyc(); i_enable = 1'b1;
      cyc(); i_enable = 1'b0;
      cyc(); i_redir_valid = 1'b1; i_redir_kind = 2'b00; i_redir_target = 32'h0000_0102;
      cyc(); quiet(); i_imem_rsp_valid = 1'b1; #1;
      checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL mis_flush: got %b want 1", o_flush); end
`ifdef PCSEQ_MISALIGN_TRAP_EN
      checks++; if (o_trap !== 1'b1 || o_trap_addr !== 32'h0000_0102) begin errors++; $display("FAIL mis_trap: got t=%b a=%h want t=1 a=00000102", o_trap, o_trap_addr); end
      cyc(); quiet(); #1;
      checks++; if (o_pc_op !== 3'(PcStop) || o_halted !== 1'b1) begin errors++; $display("FAIL mis_halt: got op=%0d h=%b want op=0 h=1", o_pc_op, o_halted); end
`else
      cyc(); quiet(); #1;
      checks++; if (o_pc_op !== 3'(PcJAL) || o_halted !== 1'b0) begin errors++; $display("FAIL mis_jal: got op=%0d h=%b want op=2 h=0", o_pc_op, o_halted); end
`endif
   endtask

   initial begin
      test_reset();
      test_throughput();
      test_stall();
      test_redirect_wait();
      test_back_to_back();
      test_halt();
      test_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
